// File: rtl/psum_drain_pkg.sv
// Shared constants and FSM encoding for the partial-sum drain path.
// Pixel packing geometry and requantization limits live here so the top and bench agree.
package psum_drain_pkg;

    localparam int OUT_W  = 8;
    localparam int PACK   = 4;
    localparam int WORD_W = PACK * OUT_W;
    localparam int LANE_W = $clog2(PACK);

    localparam logic [OUT_W-1:0] SAT_MAX = {OUT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/psum_wr_fifo.sv
// Synchronous word FIFO holding {address, data} for the output SRAM write port.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module psum_wr_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Requantizes the post-ReLU psum stream to 8 bits, packs four pixels per word and
// streams the words to the output feature-map SRAM, reporting completion of one plane.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int DATA_W     = 25,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        cfg_shift,
    input  logic [7:0]        cfg_row_len,
    input  logic [7:0]        cfg_num_rows,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    state_e state_q, state_d;

    logic [4:0]        shift_q;
    logic [7:0]        row_len_q, num_rows_q, pix_cnt_q, row_cnt_q;
    logic              in_done_q;
    logic              q_valid_q, q_last_row_q, q_last_plane_q;
    logic [OUT_W-1:0]  q_pix_q;
    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] acc_q, acc_d, word_q;
    logic              word_valid_q;
    logic [ADDR_W-1:0] push_addr_q;
    logic              overflow_q;

    logic start_acc, accept, last_row, last_plane, pop, fifo_full, fifo_empty;
    logic [ADDR_W+WORD_W-1:0] fifo_head;

    // Negative values clamp to zero; the rounding add carries one spare bit so it cannot wrap.
    function automatic logic [OUT_W-1:0] requant(input logic [DATA_W-1:0] x, input logic [4:0] s);
        logic [DATA_W:0] sum;
        logic [DATA_W:0] q;
        sum = {1'b0, x};
        if (s != 5'd0) begin
            sum = sum + ((DATA_W+1)'(1) << (s - 5'd1));
        end
        q = sum >> s;
        if (x[DATA_W-1]) begin
            return '0;
        end
        if (q > (DATA_W+1)'(SAT_MAX)) begin
            return SAT_MAX;
        end
        return q[OUT_W-1:0];
    endfunction

    assign start_acc  = start && (state_q == ST_IDLE);
    assign accept     = in_valid && (state_q == ST_RUN) && !in_done_q;
    assign last_row   = (pix_cnt_q == row_len_q - 8'd1);
    assign last_plane = last_row && (row_cnt_q == num_rows_q - 8'd1);
    assign pop        = wr_en && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_row_len == 8'd0 || cfg_num_rows == 8'd0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (q_valid_q && q_last_plane_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty && !word_valid_q && !q_valid_q) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        acc_d[int'(lane_q)*OUT_W +: OUT_W] = q_pix_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q        <= '0;
            row_len_q      <= '0;
            num_rows_q     <= '0;
            pix_cnt_q      <= '0;
            row_cnt_q      <= '0;
            in_done_q      <= 1'b0;
            q_valid_q      <= 1'b0;
            q_pix_q        <= '0;
            q_last_row_q   <= 1'b0;
            q_last_plane_q <= 1'b0;
            lane_q         <= '0;
            acc_q          <= '0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            push_addr_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                shift_q    <= cfg_shift;
                row_len_q  <= cfg_row_len;
                num_rows_q <= cfg_num_rows;
                pix_cnt_q  <= '0;
                row_cnt_q  <= '0;
                in_done_q  <= 1'b0;
            end else if (accept) begin
                if (last_row) begin
                    pix_cnt_q <= '0;
                    row_cnt_q <= row_cnt_q + 8'd1;
                end else begin
                    pix_cnt_q <= pix_cnt_q + 8'd1;
                end
                if (last_plane) begin
                    in_done_q <= 1'b1;
                end
            end

            q_valid_q <= accept;
            if (accept) begin
                q_pix_q        <= requant(in_data, shift_q);
                q_last_row_q   <= last_row;
                q_last_plane_q <= last_plane;
            end

            word_valid_q <= 1'b0;
            if (start_acc) begin
                acc_q  <= '0;
                lane_q <= '0;
            end else if (q_valid_q) begin
                if (lane_q == LANE_W'(PACK-1) || q_last_row_q) begin
                    word_q       <= acc_d;
                    word_valid_q <= 1'b1;
                    acc_q        <= '0;
                    lane_q       <= '0;
                end else begin
                    acc_q  <= acc_d;
                    lane_q <= lane_q + 1'b1;
                end
            end

            // Addresses are bound at push time, so dropped words do not consume one.
            if (start_acc) begin
                push_addr_q <= cfg_base_addr;
                overflow_q  <= 1'b0;
            end else if (word_valid_q) begin
                if (!fifo_full || pop) begin
                    push_addr_q <= push_addr_q + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    psum_wr_fifo #(
        .WIDTH (ADDR_W + WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (word_valid_q),
        .pop_i   (pop),
        .data_i  ({push_addr_q, word_q}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_en    = !fifo_empty;
    assign wr_addr  = wr_en ? fifo_head[WORD_W +: ADDR_W] : '0;
    assign wr_data  = wr_en ? fifo_head[WORD_W-1:0] : '0;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: directed plan scenarios plus randomized planes
// checked against a plain-arithmetic reference of requantization and row packing.
module tb_psum_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_row_len, cfg_num_rows;
    logic [11:0] cfg_base_addr;
    logic [24:0] in_data;
    logic        in_valid;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        busy, done, overflow;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 1;
    int          done_cnt = 0;
    wr_t         got_q[$];
    int          px_q[$];
    logic [31:0] exp_q[$];

    logic        prev_pending = 1'b0;
    logic [11:0] prev_addr;
    logic [31:0] prev_data;

    psum_drain dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_shift     (cfg_shift),
        .cfg_row_len   (cfg_row_len),
        .cfg_num_rows  (cfg_num_rows),
        .cfg_base_addr (cfg_base_addr),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Observes the write port away from the rising edge: logs accepted writes, counts
    // done pulses and checks that a stalled request holds its address and data.
    always @(negedge clk) begin
        if (rst_n && prev_pending) begin
            n_checks++;
            if (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data)
                $display("FAIL stall_hold: got en=%b addr=%h data=%h, expected en=1 addr=%h data=%h",
                         wr_en, wr_addr, wr_data, prev_addr, prev_data);
            if (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data) n_fail++;
        end
        prev_pending = rst_n && wr_en && !wr_ready;
        prev_addr    = wr_addr;
        prev_data    = wr_data;
        if (rst_n && wr_en && wr_ready) got_q.push_back('{a: wr_addr, d: wr_data});
        if (rst_n && done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    function automatic int quant_ref(input longint x, input int s);
        longint q;
        if (x < 0) return 0;
        if (s == 0) q = x;
        else q = (x + (longint'(1) << (s - 1))) / (longint'(1) << s);
        return (q > 255) ? 255 : int'(q);
    endfunction

    // Expected words: each row split into ceil(len/4) words, first pixel in the low byte.
    function automatic void build_expected(input int s, input int len, input int rows);
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int w = 0; w < (len + 3) / 4; w++) begin
                logic [31:0] word = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    if (w * 4 + k < len)
                        word = word | (32'(quant_ref(px_q[r * len + w * 4 + k], s)) << (8 * k));
                end
                exp_q.push_back(word);
            end
        end
    endfunction

    task automatic run_plane(input string name, input int s, input int len, input int rows,
                             input int base, input int mode, input bit gaps, input bit exp_ovf);
        int budget;
        got_q.delete();
        done_cnt = 0;
        rdy_mode = mode;
        cfg_shift     = 5'(s);
        cfg_row_len   = 8'(len);
        cfg_num_rows  = 8'(rows);
        cfg_base_addr = 12'(base);
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (px_q[i]) begin
            while (gaps && $urandom_range(0, 2) == 0) tick();
            in_data  = 25'(px_q[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        // Pixels beyond the plane must be discarded.
        in_data  = 25'h0ABCDE;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        if (mode == 0) begin
            repeat (6) tick();
            rdy_mode = 1;
        end
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            tick();
            budget++;
        end
        tick();
        tick();
        n_checks++;
        if (done_cnt != 1) begin
            $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt);
            n_fail++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_busy: got %b, expected 0", name, busy);
            n_fail++;
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL %s_count: got %0d writes, expected %0d", name, got_q.size(), exp_q.size());
            n_fail++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            logic [11:0] ea = 12'(base + i);
            n_checks++;
            if (got_q[i].a !== ea || got_q[i].d !== exp_q[i]) begin
                $display("FAIL %s_write%0d: got addr=%h data=%h, expected addr=%h data=%h",
                         name, i, got_q[i].a, got_q[i].d, ea, exp_q[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (overflow !== exp_ovf) begin
            $display("FAIL %s_overflow: got %b, expected %b", name, overflow, exp_ovf);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, done, overflow} !== '0) begin
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b ovf=%b, expected all 0",
                     wr_en, wr_addr, wr_data, busy, done, overflow);
            n_fail++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        px_q  = '{16, 40, 4095, -5};
        exp_q = '{32'h00FF0301};
        run_plane("single_word", 4, 4, 1, 'h010, 1, 1'b0, 1'b0);
    endtask

    task automatic test_two_rows();
        px_q = '{};
        for (int i = 1; i <= 12; i++) px_q.push_back(i);
        exp_q = '{32'h04030201, 32'h00000605, 32'h0A090807, 32'h00000C0B};
        run_plane("two_rows", 0, 6, 2, 'h000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_rounding();
        px_q  = '{3, 5, 600};
        exp_q = '{32'h00FF0302};
        run_plane("rounding", 1, 3, 1, 'h200, 2, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        px_q = '{};
        for (int i = 0; i < 40; i++) px_q.push_back(i * 16 + 7);
        build_expected(4, 40, 1);
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        run_plane("overflow", 4, 40, 1, 'h3F0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_rows();
        int busy_cycles = 0;
        int en_cycles   = 0;
        done_cnt = 0;
        rdy_mode = 1;
        cfg_row_len  = 8'd5;
        cfg_num_rows = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_cycles++;
            if (wr_en) en_cycles++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (busy_cycles != 1 || done_cnt != 1 || en_cycles != 0) begin
            $display("FAIL zero_rows: got busy=%0d done=%0d wr_en=%0d cycles, expected 1 1 0",
                     busy_cycles, done_cnt, en_cycles);
            n_fail++;
        end
    endtask

    task automatic test_reset_midrow();
        rdy_mode = 0;
        cfg_shift     = 5'd0;
        cfg_row_len   = 8'd8;
        cfg_num_rows  = 8'd2;
        cfg_base_addr = 12'h123;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data  = 25'(i + 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'h123 || wr_data !== 32'h04030201) begin
            $display("FAIL pre_reset_word: got en=%b addr=%h data=%h, expected en=1 addr=123 data=04030201",
                     wr_en, wr_addr, wr_data);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, done, overflow} !== '0) begin
            $display("FAIL midrow_reset: got en=%b addr=%h data=%h busy=%b done=%b ovf=%b, expected all 0",
                     wr_en, wr_addr, wr_data, busy, done, overflow);
            n_fail++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        px_q  = '{10, 20, 30, 40};
        exp_q = '{32'h281E140A};
        run_plane("after_reset", 0, 4, 1, 'h055, 1, 1'b0, 1'b0);
    endtask

    // Planes never exceed the FIFO depth in total words, so overflow must stay clear.
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int s    = $urandom_range(0, 12);
            int rows = $urandom_range(1, 4);
            int len  = $urandom_range(1, (rows <= 2) ? 16 : 8);
            int base = (it == 0) ? 'hFFE : $urandom_range(0, 4095);
            px_q = '{};
            for (int i = 0; i < rows * len; i++) begin
                case ($urandom_range(0, 3))
                    0:       px_q.push_back(int'($urandom_range(0, 33554431)) - 16777216);
                    1:       px_q.push_back($urandom_range(0, 600));
                    2:       px_q.push_back((255 << s) + $urandom_range(0, 3 << s) - (1 << s));
                    default: px_q.push_back($urandom_range(0, 16777215));
                endcase
            end
            build_expected(s, len, rows);
            run_plane($sformatf("random%0d", it), s, len, rows, base, 2, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        cfg_shift     = '0;
        cfg_row_len   = '0;
        cfg_num_rows  = '0;
        cfg_base_addr = '0;
        in_data       = '0;
        in_valid      = 1'b0;
        wr_ready      = 1'b1;
        test_reset();
        test_single_word();
        test_two_rows();
        test_rounding();
        test_overflow();
        test_zero_rows();
        test_reset_midrow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
